// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM access controller: FSM state encoding,
// default bus widths and a helper for sizing the wait-state counter.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } state_t;

  // Counter must hold the value n itself; never narrower than one bit.
  function automatic int cntWidth(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ram_ctrl_mem.sv
// Word-addressed single-port RAM with synchronous write and registered read.
// Contents are deliberately not reset.
module ram_ctrl_mem
  import ram_ctrl_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = DEF_DATA_W,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_weEn,
  input  logic              i_rdEn,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_weEn) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_rdEn) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_access_ctrl.sv
// Single-word RAM access controller: req/ack handshake, programmable wait
// states and out-of-range address flagging (no aliasing onto the RAM).
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addressIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              ack,
  output logic              busy,
  output logic              addrErr
);

  localparam int                MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W     = cntWidth(WAIT_STATES);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t r_state;
  state_t w_nextState;

  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_ack;
  logic              r_addrErr;
  logic              r_busy;
  logic              r_rdZero;

  logic              w_accept;
  logic              w_access;
  logic              w_inRange;
  logic              w_memWe;
  logic              w_memRe;
  logic [DATA_W-1:0] w_memQ;

  // Full-width compare: high address bits must be zero, so nothing wraps.
  assign w_inRange = ({1'b0, r_addr} < DEPTH_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_accept    = 1'b1;
          w_nextState = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == CNT_ONE) begin
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        w_access    = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_memWe = w_access &  r_we & w_inRange;
  assign w_memRe = w_access & ~r_we & w_inRange;

  // r_rdZero selects a zero read result (after reset or a bad address)
  // without having to clear the RAM's own read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_ack     <= 1'b0;
      r_addrErr <= 1'b0;
      r_busy    <= 1'b0;
      r_rdZero  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_addr  <= addressIn;
        r_wdata <= dataIn;
        r_we    <= we;
        r_busy  <= 1'b1;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_ONE;
      end

      if (w_access) begin
        r_ack     <= 1'b1;
        r_addrErr <= ~w_inRange;
        if (!w_inRange) begin
          r_rdZero <= 1'b1;
        end else if (!r_we) begin
          r_rdZero <= 1'b0;
        end
      end else if (r_state == DONE) begin
        r_ack     <= 1'b0;
        r_addrErr <= 1'b0;
        r_busy    <= 1'b0;
      end
    end
  end

  ram_ctrl_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (MEM_AW)
  ) u_mem (
    .clk     (clk),
    .i_weEn  (w_memWe),
    .i_rdEn  (w_memRe),
    .i_addr  (r_addr[MEM_AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_memQ)
  );

  assign dataOut = r_rdZero ? '0 : w_memQ;
  assign ack     = r_ack;
  assign busy    = r_busy;
  assign addrErr = r_addrErr;

endmodule
